ysyx_23060236_bpu: RTL and testbench

- Parametrised set-associative branch target buffer with a saturating-counter direction predictor per entry and tree pseudo-LRU replacement.
- Sits beside IFU/EXU. IFU uses the fetch read port to pick the next PC. EXU uses the second read port to check the prediction. EXU drives the single update port on branch/jump resolution.

---
 rtl/ysyx_23060236_bpu_pkg.sv | 32 +++
 rtl/ysyx_23060236_plru.sv | 54 +++++
 rtl/ysyx_23060236_bpu.sv | 158 +++++++++++++++
 tb/tb_ysyx_23060236_bpu.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060236_bpu_pkg.sv
// Shared constants for the branch predictor: default geometry, counter
// encodings and PLRU tree sizing helpers.
package ysyx_23060236_bpu_pkg;

   localparam int BPU_ADDR_LEN   = 32;
   localparam int BPU_OFFSET_LEN = 2;
   localparam int BPU_INDEX_LEN  = 2;
   localparam int BPU_WAYS       = 2;
   localparam int BPU_CNT_LEN    = 2;

   // Counter encodings as plain ints; the top casts them to CNT_LEN bits.
   localparam int CNT_MIN = 0;

   function automatic int cnt_weak_taken(int len);
      return 1 << (len - 1);
   endfunction

   function automatic int cnt_max(int len);
      return (1 << len) - 1;
   endfunction

   // A single-way set has no tree, but keeps one unused bit so that
   // vector declarations stay legal.
   function automatic int plru_nodes(int ways);
      return (ways > 1) ? ways - 1 : 1;
   endfunction

   function automatic int way_bits(int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/ysyx_23060236_plru.sv
// Tree pseudo-LRU next-state and victim logic for one set. Heap-ordered nodes
// with the root at bit 0; a node bit of 1 points the victim walk right.
module ysyx_23060236_plru
   import ysyx_23060236_bpu_pkg::*;
#(
   parameter int WAYS  = BPU_WAYS,
   parameter int NODES = plru_nodes(WAYS),
   parameter int WAY_W = way_bits(WAYS)
) (
   input  logic [NODES-1:0] tree,
   input  logic [WAY_W-1:0] touch_way,
   output logic [NODES-1:0] next_tree,
   output logic [WAY_W-1:0] victim
);

   if (WAYS == 1) begin : g_single
      logic unused_in;
      assign unused_in = ^{tree, touch_way};
      assign next_tree = tree;
      assign victim    = '0;
   end else begin : g_tree
      localparam int LEVELS = $clog2(WAYS);
      localparam int NW     = LEVELS + 1;

      // Padded to 2*WAYS bits so a LEVELS+1 bit heap index selects it exactly.
      logic [2*WAYS-1:0] ext, next_ext;
      logic [NW-1:0]     node_t, node_v;
      logic              dir;
      logic              unused_hi;

      assign ext = {{(WAYS + 1){1'b0}}, tree};

      always_comb begin
         next_ext = ext;
         node_t   = '0;
         dir      = 1'b0;
         for (int l = 0; l < LEVELS; l++) begin
            dir              = touch_way[LEVELS-1-l];
            next_ext[node_t] = ~dir;
            node_t           = NW'({node_t, 1'b0}) + NW'(1) + NW'(dir);
         end
         victim = '0;
         node_v = '0;
         for (int l = 0; l < LEVELS; l++) begin
            victim[LEVELS-1-l] = ext[node_v];
            node_v             = NW'({node_v, 1'b0}) + NW'(1) + NW'(ext[node_v]);
         end
      end

      assign next_tree = next_ext[NODES-1:0];
      assign unused_hi = ^next_ext[2*WAYS-1:NODES];
   end

endmodule

// File: rtl/ysyx_23060236_bpu.sv
// Set-associative BTB with per-entry saturating direction counters, two
// combinational lookup ports (fetch, execute) and one resolution update port.
module ysyx_23060236_bpu
   import ysyx_23060236_bpu_pkg::*;
#(
   parameter int ADDR_LEN   = BPU_ADDR_LEN,
   parameter int OFFSET_LEN = BPU_OFFSET_LEN,
   parameter int INDEX_LEN  = BPU_INDEX_LEN,
   parameter int WAYS       = BPU_WAYS,
   parameter int CNT_LEN    = BPU_CNT_LEN
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                flush,
   input  logic [ADDR_LEN-1:0] pc_f,
   output logic [ADDR_LEN-1:0] pred_npc_f,
   output logic                pred_taken_f,
   input  logic [ADDR_LEN-1:0] pc_e,
   output logic [ADDR_LEN-1:0] pred_npc_e,
   output logic                pred_taken_e,
   input  logic                upd_valid,
   input  logic [ADDR_LEN-1:0] upd_pc,
   input  logic [ADDR_LEN-1:0] upd_target,
   input  logic                upd_taken
);

   localparam int SETS    = 1 << INDEX_LEN;
   localparam int TAG_LO  = OFFSET_LEN + INDEX_LEN;
   localparam int TAG_LEN = ADDR_LEN - TAG_LO;
   localparam int NODES   = plru_nodes(WAYS);
   localparam int WAY_W   = way_bits(WAYS);

   localparam logic [CNT_LEN-1:0] CNT_WEAK_TAKEN = CNT_LEN'(cnt_weak_taken(CNT_LEN));
   localparam logic [CNT_LEN-1:0] CNT_MAX        = CNT_LEN'(cnt_max(CNT_LEN));
   localparam logic [CNT_LEN-1:0] CNT_ZERO       = CNT_LEN'(CNT_MIN);

   logic [SETS-1:0][WAYS-1:0] valid;
   logic [TAG_LEN-1:0]        tags    [SETS][WAYS];
   logic [ADDR_LEN-1:0]       targets [SETS][WAYS];
   logic [CNT_LEN-1:0]        cnts    [SETS][WAYS];
   logic [NODES-1:0]          plru    [SETS];

   // ---------------- lookup ports: 0 = fetch, 1 = execute ----------------
   logic [ADDR_LEN-1:0] rd_pc    [2];
   logic [ADDR_LEN-1:0] rd_npc   [2];
   logic                rd_taken [2];

   assign rd_pc[0]     = pc_f;
   assign rd_pc[1]     = pc_e;
   assign pred_npc_f   = rd_npc[0];
   assign pred_taken_f = rd_taken[0];
   assign pred_npc_e   = rd_npc[1];
   assign pred_taken_e = rd_taken[1];

   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic [INDEX_LEN-1:0] idx;
      logic [TAG_LEN-1:0]   tag;
      logic                 taken;
      logic [ADDR_LEN-1:0]  tgt;

      assign idx = rd_pc[p][TAG_LO-1:OFFSET_LEN];
      assign tag = rd_pc[p][ADDR_LEN-1:TAG_LO];

      always_comb begin
         taken = 1'b0;
         tgt   = '0;
         for (int w = 0; w < WAYS; w++) begin
            if (valid[idx][w] && tags[idx][w] == tag) begin
               taken = cnts[idx][w][CNT_LEN-1];
               tgt   = targets[idx][w];
            end
         end
      end

      assign rd_taken[p] = taken;
      assign rd_npc[p]   = taken ? tgt : rd_pc[p] + ADDR_LEN'(4);
   end

   // ---------------- update port ----------------
   logic [INDEX_LEN-1:0] u_idx;
   logic [TAG_LEN-1:0]   u_tag;
   logic                 u_hit, any_inv;
   logic [WAY_W-1:0]     hit_way, inv_way, plru_victim, victim, touch_way;
   logic [NODES-1:0]     plru_next;
   logic [CNT_LEN-1:0]   cnt_cur, cnt_next;
   logic                 unused_off;

   assign u_idx      = upd_pc[TAG_LO-1:OFFSET_LEN];
   assign u_tag      = upd_pc[ADDR_LEN-1:TAG_LO];
   assign unused_off = ^upd_pc[OFFSET_LEN-1:0];

   always_comb begin
      u_hit   = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid[u_idx][w] && tags[u_idx][w] == u_tag) begin
            u_hit   = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
      // Scanning downward leaves the lowest-numbered invalid way selected.
      any_inv = 1'b0;
      inv_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid[u_idx][w]) begin
            any_inv = 1'b1;
            inv_way = WAY_W'(w);
         end
      end
   end

   assign victim    = any_inv ? inv_way : plru_victim;
   assign touch_way = u_hit ? hit_way : victim;

   ysyx_23060236_plru #(
      .WAYS  (WAYS),
      .NODES (NODES),
      .WAY_W (WAY_W)
   ) u_plru (
      .tree      (plru[u_idx]),
      .touch_way (touch_way),
      .next_tree (plru_next),
      .victim    (plru_victim)
   );

   always_comb begin
      cnt_cur  = cnts[u_idx][hit_way];
      cnt_next = cnt_cur;
      if (upd_taken) begin
         if (cnt_cur != CNT_MAX) cnt_next = cnt_cur + CNT_LEN'(1);
      end else begin
         if (cnt_cur != CNT_ZERO) cnt_next = cnt_cur - CNT_LEN'(1);
      end
   end

   // Tags, targets and counters carry no reset; valid bits gate them.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid <= '0;
         for (int s = 0; s < SETS; s++) plru[s] <= '0;
      end else if (flush) begin
         valid <= '0;
      end else if (upd_valid) begin
         if (u_hit) begin
            cnts[u_idx][hit_way] <= cnt_next;
            if (upd_taken) targets[u_idx][hit_way] <= upd_target;
            plru[u_idx] <= plru_next;
         end else if (upd_taken) begin
            valid[u_idx][victim]   <= 1'b1;
            tags[u_idx][victim]    <= u_tag;
            targets[u_idx][victim] <= upd_target;
            cnts[u_idx][victim]    <= CNT_WEAK_TAKEN;
            plru[u_idx]            <= plru_next;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_23060236_bpu.sv
// Directed bench for the BTB: lookups, counter saturation, PLRU eviction,
// flush and reset priority over a concurrent update.
module tb_ysyx_23060236_bpu;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] pc_f = '0, pc_e = '0;
   logic [31:0] pred_npc_f, pred_npc_e;
   logic        pred_taken_f, pred_taken_e;
   logic        upd_valid = 1'b0, upd_taken = 1'b0;
   logic [31:0] upd_pc = '0, upd_target = '0;

   int checks   = 0;
   int failures = 0;

   ysyx_23060236_bpu dut (
      .clock        (clock),
      .reset        (reset),
      .flush        (flush),
      .pc_f         (pc_f),
      .pred_npc_f   (pred_npc_f),
      .pred_taken_f (pred_taken_f),
      .pc_e         (pc_e),
      .pred_npc_e   (pred_npc_e),
      .pred_taken_e (pred_taken_e),
      .upd_valid    (upd_valid),
      .upd_pc       (upd_pc),
      .upd_target   (upd_target),
      .upd_taken    (upd_taken)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
      upd_valid  = 1'b1;
      upd_pc     = pc;
      upd_target = tgt;
      upd_taken  = tk;
      step();
      upd_valid  = 1'b0;
   endtask

   task automatic look(input string tag, input logic [31:0] pc, input logic tk,
                       input logic [31:0] npc);
      pc_f = pc;
      pc_e = pc;
      #1;
      chk({tag, "_taken_f"}, 32'(pred_taken_f), 32'(tk));
      chk({tag, "_npc_f"},   pred_npc_f,        npc);
      chk({tag, "_taken_e"}, 32'(pred_taken_e), 32'(tk));
      chk({tag, "_npc_e"},   pred_npc_e,        npc);
   endtask

   initial begin
      // 1: reset state, pc+4 with wraparound
      pc_f = 32'h8000_0000;
      pc_e = 32'hFFFF_FFFC;
      step();
      step();
      chk("rst_taken_f", 32'(pred_taken_f), 32'd0);
      chk("rst_npc_f",   pred_npc_f,        32'h8000_0004);
      chk("rst_taken_e", 32'(pred_taken_e), 32'd0);
      chk("rst_npc_e",   pred_npc_e,        32'h0000_0000);
      reset = 1'b0;
      step();

      // 2: allocate, no bypass in the update cycle
      upd_valid  = 1'b1;
      upd_pc     = 32'h8000_0010;
      upd_target = 32'h8000_0100;
      upd_taken  = 1'b1;
      pc_f = 32'h8000_0010;
      pc_e = 32'h8000_0010;
      #1;
      chk("upd_cycle_npc_f", pred_npc_f, 32'h8000_0014);
      chk("upd_cycle_npc_e", pred_npc_e, 32'h8000_0014);
      step();
      upd_valid = 1'b0;
      look("alloc", 32'h8000_0010, 1'b1, 32'h8000_0100);

      // 3: counter walk from weakly taken, target kept on not-taken
      upd(32'h8000_0010, 32'hDEAD_0000, 1'b0);                     // 01
      look("cnt01", 32'h8000_0010, 1'b0, 32'h8000_0014);
      upd(32'h8000_0010, 32'h8000_0100, 1'b1);                     // 10
      upd(32'h8000_0010, 32'h8000_0100, 1'b1);                     // 11
      look("cnt11", 32'h8000_0010, 1'b1, 32'h8000_0100);
      upd(32'h8000_0010, 32'h1234_5678, 1'b0);                     // 10
      look("cnt10", 32'h8000_0010, 1'b1, 32'h8000_0100);
      // saturation at the top: 11, 11, then two not-taken -> 01
      upd(32'h8000_0010, 32'h8000_0100, 1'b1);
      upd(32'h8000_0010, 32'h8000_0100, 1'b1);
      upd(32'h8000_0010, 32'h8000_0100, 1'b1);
      upd(32'h8000_0010, 32'h8000_0100, 1'b0);
      upd(32'h8000_0010, 32'h8000_0100, 1'b0);
      look("sat_hi", 32'h8000_0010, 1'b0, 32'h8000_0014);
      // saturation at the bottom: 00, 00, then one taken -> 01, one more -> 10
      upd(32'h8000_0010, 32'h8000_0100, 1'b0);
      upd(32'h8000_0010, 32'h8000_0100, 1'b0);
      upd(32'h8000_0010, 32'h8000_0100, 1'b1);
      look("sat_lo", 32'h8000_0010, 1'b0, 32'h8000_0014);
      upd(32'h8000_0010, 32'h8000_0100, 1'b1);
      look("sat_lo_up", 32'h8000_0010, 1'b1, 32'h8000_0100);

      // 4: set 0 replacement; A in way 0, B fills way 1, A touched, C evicts B
      upd(32'h8000_0050, 32'h8000_0200, 1'b1);
      upd(32'h8000_0010, 32'h8000_0100, 1'b1);
      upd(32'h8000_0090, 32'h8000_0300, 1'b1);
      look("repl_a", 32'h8000_0010, 1'b1, 32'h8000_0100);
      look("repl_c", 32'h8000_0090, 1'b1, 32'h8000_0300);
      look("repl_b", 32'h8000_0050, 1'b0, 32'h8000_0054);

      // 5: not-taken miss allocates nothing; flush beats a concurrent update
      upd(32'h8000_0020, 32'h8000_0400, 1'b0);
      look("nt_miss", 32'h8000_0020, 1'b0, 32'h8000_0024);
      flush = 1'b1;
      upd(32'h8000_0030, 32'h8000_0500, 1'b1);
      flush = 1'b0;
      look("flush_a",   32'h8000_0010, 1'b0, 32'h8000_0014);
      look("flush_c",   32'h8000_0090, 1'b0, 32'h8000_0094);
      look("flush_upd", 32'h8000_0030, 1'b0, 32'h8000_0034);

      // 6: fill all 8 entries, then reset with a concurrent update
      for (int s = 0; s < 4; s++) begin
         upd(32'h8000_0000 + 32'(4 * s), 32'h9000_0000 + 32'(4 * s), 1'b1);
         upd(32'h8000_0100 + 32'(4 * s), 32'hA000_0000 + 32'(4 * s), 1'b1);
      end
      for (int s = 0; s < 4; s++) begin
         look("fill0", 32'h8000_0000 + 32'(4 * s), 1'b1, 32'h9000_0000 + 32'(4 * s));
         look("fill1", 32'h8000_0100 + 32'(4 * s), 1'b1, 32'hA000_0000 + 32'(4 * s));
      end
      reset = 1'b1;
      upd(32'h8000_0200, 32'h8000_0600, 1'b1);
      reset = 1'b0;
      for (int s = 0; s < 4; s++) begin
         look("rst0", 32'h8000_0000 + 32'(4 * s), 1'b0, 32'h8000_0004 + 32'(4 * s));
         look("rst1", 32'h8000_0100 + 32'(4 * s), 1'b0, 32'h8000_0104 + 32'(4 * s));
      end
      look("rst_upd", 32'h8000_0200, 1'b0, 32'h8000_0204);

      // After reset: X -> way 0, Y -> way 1, so PLRU then names X as victim for Z
      upd(32'h8000_0000, 32'h8000_0700, 1'b1);
      upd(32'h8000_0040, 32'h8000_0800, 1'b1);
      upd(32'h8000_0080, 32'h8000_0900, 1'b1);
      look("post_x", 32'h8000_0000, 1'b0, 32'h8000_0004);
      look("post_y", 32'h8000_0040, 1'b1, 32'h8000_0800);
      look("post_z", 32'h8000_0080, 1'b1, 32'h8000_0900);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
